// File: rtl/io_display_unit.sv
// I/O port: IN handshake that stalls the PC, CHANNELS output registers, and a sequential
// double-dabble BCD converter driving DIGITS 7-seg displays. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module io_display_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int IN_WIDTH     = 18,
  parameter int DIGITS       = 8,
  parameter int CH_SEL_WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_request,
  input  logic                    input_ready,
  input  logic [IN_WIDTH-1:0]     switches,
  output logic                    stall,
  output logic [DATA_WIDTH-1:0]   data_output,
  input  logic                    out_write,
  input  logic [CH_SEL_WIDTH-1:0] out_channel,
  input  logic [DATA_WIDTH-1:0]   out_data,
  input  logic [CH_SEL_WIDTH-1:0] view_select,
  output logic [4*DIGITS-1:0]     digits,
  output logic [7*DIGITS-1:0]     segments,
  output logic                    busy,
  output logic                    overflow
);

  localparam int CHANNELS = 2**CH_SEL_WIDTH;
  localparam int BCD_W    = 4*DIGITS;
  localparam int CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IN_IDLE, IN_WAIT, IN_DONE} in_state_t;
  typedef enum logic [1:0] {CV_IDLE, CV_LOAD, CV_SHIFT} cv_state_t;

  in_state_t in_state, in_next;
  logic      ready_q, ready_rise, in_capture;

  assign ready_rise = input_ready & ~ready_q;
  assign stall      = in_request & (in_state != IN_DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      in_state    <= IN_IDLE;
      ready_q     <= 1'b0;
      data_output <= '0;
    end else begin
      in_state <= in_next;
      ready_q  <= input_ready;
      if (in_capture) data_output <= DATA_WIDTH'(switches);
    end
  end

  // NOTE: every output of a combinational block is defaulted first so no path infers a latch.
  always_comb begin
    in_next    = in_state;
    in_capture = 1'b0;
    case (in_state)
      IN_IDLE: if (in_request) in_next = IN_WAIT;
      IN_WAIT: if (ready_rise) begin
        in_next    = IN_DONE;
        in_capture = 1'b1;
      end
      IN_DONE: in_next = IN_IDLE;
      default: in_next = IN_IDLE;
    endcase
  end

  logic [DATA_WIDTH-1:0]   channel [CHANNELS];
  logic [CH_SEL_WIDTH-1:0] view_q;
  logic                    write_en, dirty, dirty_set;

  assign write_en  = out_write & ~stall;
  assign dirty_set = (write_en && out_channel == view_select) || (view_select != view_q);

  // NOTE: the register file is reset explicitly because its contents are architecturally visible.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) channel[i] <= '0;
      view_q <= view_select;
    end else begin
      if (write_en) channel[out_channel] <= out_data;
      view_q <= view_select;
    end
  end

  cv_state_t             cv_state, cv_next;
  logic [DATA_WIDTH-1:0] snap;
  logic [BCD_W-1:0]      bcd, bcd_adj, bcd_shifted;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf_tmp, ovf_final, last;
  logic [7*DIGITS-1:0]   seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign busy = (cv_state != CV_IDLE);
  assign last = (cnt == CNT_W'(DATA_WIDTH-1));

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    bcd_shifted = {bcd_adj[BCD_W-2:0], snap[DATA_WIDTH-1]};
    ovf_final   = ovf_tmp | bcd_adj[BCD_W-1];
  end

  // Segment image of the result about to be latched; only sampled on the last shift.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic seen;
    seen = 1'b0;
`endif
    seg_next = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      seg_next[7*i +: 7] = seg7(bcd_shifted[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_shifted[4*i +: 4] != 4'd0) seen = 1'b1;
      if (!seen && i != 0) seg_next[7*i +: 7] = 7'h7F;
`endif
      if (ovf_final) seg_next[7*i +: 7] = 7'b0111111;
    end
  end

  // A dirty flag raised mid-conversion chains straight into a new load so busy never drops.
  always_comb begin
    cv_next = cv_state;
    case (cv_state)
      CV_IDLE:  if (dirty) cv_next = CV_LOAD;
      CV_LOAD:  cv_next = CV_SHIFT;
      CV_SHIFT: if (last) cv_next = dirty ? CV_LOAD : CV_IDLE;
      default:  cv_next = CV_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cv_state <= CV_IDLE;
      dirty    <= 1'b1;
      snap     <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_tmp  <= 1'b0;
      digits   <= '0;
      segments <= '1;
      overflow <= 1'b0;
    end else begin
      cv_state <= cv_next;
      if (dirty_set) dirty <= 1'b1;
      else if (cv_state == CV_LOAD) dirty <= 1'b0;
      case (cv_state)
        CV_LOAD: begin
          snap    <= channel[view_select];
          bcd     <= '0;
          cnt     <= '0;
          ovf_tmp <= 1'b0;
        end
        CV_SHIFT: begin
          snap    <= snap << 1;
          bcd     <= bcd_shifted;
          cnt     <= cnt + 1'b1;
          ovf_tmp <= ovf_final;
          if (last) begin
            digits   <= ovf_final ? '0 : bcd_shifted;
            overflow <= ovf_final;
            segments <= seg_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_display_unit.sv
// Directed self-checking bench for io_display_unit: reset, conversion latency, IN handshake,
// overflow, view change during conversion and leading-zero display.
module tb_io_display_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_request, input_ready, out_write;
  logic [17:0] switches;
  logic        stall, busy, overflow;
  logic [31:0] data_output, out_data, digits;
  logic [1:0]  out_channel, view_select;
  logic [55:0] segments;

  int checks   = 0;
  int failures = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [55:0] SEG_ZERO  = {{7{7'h7F}}, 7'h40};
  localparam logic [55:0] SEG_12345 = {{3{7'h7F}}, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
  localparam logic [55:0] SEG_77    = {{6{7'h7F}}, 7'h78, 7'h78};
  localparam logic [55:0] SEG_SEVEN = {{7{7'h7F}}, 7'h78};
`else
  localparam logic [55:0] SEG_ZERO  = {8{7'h40}};
  localparam logic [55:0] SEG_12345 = {{3{7'h40}}, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
  localparam logic [55:0] SEG_77    = {{6{7'h40}}, 7'h78, 7'h78};
  localparam logic [55:0] SEG_SEVEN = {{7{7'h40}}, 7'h78};
`endif

  io_display_unit dut (
    .clock(clock), .reset(reset), .in_request(in_request), .input_ready(input_ready),
    .switches(switches), .stall(stall), .data_output(data_output), .out_write(out_write),
    .out_channel(out_channel), .out_data(out_data), .view_select(view_select),
    .digits(digits), .segments(segments), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_ch(input logic [1:0] ch, input logic [31:0] val);
    out_write = 1'b1; out_channel = ch; out_data = val;
    tick();
    out_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_request = 0; input_ready = 0; out_write = 0;
    switches = '0; out_channel = '0; out_data = '0; view_select = '0;
    tick(); tick();
    reset = 1'b1;
    checks++; if (stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", stall); failures++; end
    checks++; if (data_output !== 32'h0) begin $display("FAIL reset_data_output: got %h want 0", data_output); failures++; end
    checks++; if (segments !== {56{1'b1}}) begin $display("FAIL reset_segments: got %h want all 7F", segments); failures++; end
    checks++; if (digits !== 32'h0 || overflow !== 1'b0) begin $display("FAIL reset_digits: got %h/%b want 0/0", digits, overflow); failures++; end
    tick();
    checks++; if (busy !== 1'b1) begin $display("FAIL reset_conv_start: busy got %b want 1", busy); failures++; end
    repeat (33) tick();
    checks++; if (busy !== 1'b0 || digits !== 32'h0) begin $display("FAIL reset_conv_done: busy %b digits %h want 0/0", busy, digits); failures++; end
    checks++; if (segments !== SEG_ZERO) begin $display("FAIL reset_conv_segments: got %h want %h", segments, SEG_ZERO); failures++; end
  endtask

  task automatic test_convert();
    int busy_cycles = 0;
    logic held = 1'b1;
    write_ch(2'd0, 32'd12345);
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (busy) busy_cycles++;
      if (k < 34 && digits !== 32'h0) held = 1'b0;
    end
    checks++; if (busy_cycles != 33) begin $display("FAIL convert_busy_cycles: got %0d want 33", busy_cycles); failures++; end
    checks++; if (!held) begin $display("FAIL convert_no_flicker: digits changed before edge 34"); failures++; end
    checks++; if (digits !== 32'h00012345) begin $display("FAIL convert_digits: got %h want 00012345", digits); failures++; end
    checks++; if (segments[6:0] !== 7'b0010010) begin $display("FAIL convert_seg0: got %b want 0010010", segments[6:0]); failures++; end
    checks++; if (segments !== SEG_12345) begin $display("FAIL convert_segments: got %h want %h", segments, SEG_12345); failures++; end
  endtask

  task automatic test_input();
    int stalled = 0;
    in_request = 1'b1; switches = 18'h2A5; input_ready = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin $display("FAIL in_stall_comb: got %b want 1", stall); failures++; end
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin out_write = 1'b1; out_channel = 2'd0; out_data = 32'd1; end
      if (i == 1) out_write = 1'b0;
      tick();
      if (stall) stalled++;
    end
    checks++; if (stalled != 20) begin $display("FAIL in_stall_hold: got %0d want 20", stalled); failures++; end
    checks++; if (busy !== 1'b0 || digits !== 32'h00012345) begin $display("FAIL in_write_suppressed: busy %b digits %h want 0/00012345", busy, digits); failures++; end
    input_ready = 1'b1;
    tick();
    checks++; if (stall !== 1'b0) begin $display("FAIL in_done_stall: got %b want 0", stall); failures++; end
    checks++; if (data_output !== 32'h2A5) begin $display("FAIL in_capture: got %h want 000002a5", data_output); failures++; end
    switches = 18'h155;
    stalled = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (stall) stalled++;
    end
    checks++; if (stalled != 11) begin $display("FAIL in_no_retrigger: stalled %0d want 11", stalled); failures++; end
    checks++; if (data_output !== 32'h2A5) begin $display("FAIL in_hold_data: got %h want 000002a5", data_output); failures++; end
    input_ready = 1'b0; tick();
    switches = 18'h3FFFF; input_ready = 1'b1; tick();
    checks++; if (stall !== 1'b0 || data_output !== 32'h3FFFF) begin $display("FAIL in_back_to_back: stall %b data %h want 0/0003ffff", stall, data_output); failures++; end
    in_request = 1'b0; tick();
    input_ready = 1'b0; tick();
    input_ready = 1'b1; tick();
    in_request = 1'b1; tick(); tick();
    checks++; if (stall !== 1'b1) begin $display("FAIL in_idle_edge_ignored: stall %b want 1", stall); failures++; end
    input_ready = 1'b0; tick();
    switches = 18'h00001; input_ready = 1'b1; tick();
    checks++; if (stall !== 1'b0 || data_output !== 32'h1) begin $display("FAIL in_new_press: stall %b data %h want 0/00000001", stall, data_output); failures++; end
    in_request = 1'b0; input_ready = 1'b0; tick();
  endtask

  task automatic test_overflow();
    write_ch(2'd0, 32'd100000000);
    repeat (34) tick();
    checks++; if (overflow !== 1'b1 || digits !== 32'h0) begin $display("FAIL ovf_set: overflow %b digits %h want 1/0", overflow, digits); failures++; end
    checks++; if (segments !== {8{7'b0111111}}) begin $display("FAIL ovf_dashes: got %h want all 3F", segments); failures++; end
    write_ch(2'd0, 32'd99999999);
    repeat (34) tick();
    checks++; if (overflow !== 1'b0 || digits !== 32'h99999999) begin $display("FAIL ovf_max: overflow %b digits %h want 0/99999999", overflow, digits); failures++; end
    checks++; if (segments !== {8{7'h10}}) begin $display("FAIL ovf_max_segments: got %h want all 10", segments); failures++; end
  endtask

  task automatic test_view_change();
    int gaps = 0;
    write_ch(2'd1, 32'd77);
    tick();
    checks++; if (busy !== 1'b0) begin $display("FAIL view_other_channel_idle: busy %b want 0", busy); failures++; end
    write_ch(2'd0, 32'd5);
    for (int k = 1; k <= 67; k++) begin
      tick();
      if (k == 10) view_select = 2'd1;
      if (k < 67 && !busy) gaps++;
      if (k == 34) begin
        checks++; if (digits !== 32'h5) begin $display("FAIL view_first_result: got %h want 00000005", digits); failures++; end
      end
      if (k == 50) begin
        checks++; if (digits !== 32'h5) begin $display("FAIL view_hold_during_second: got %h want 00000005", digits); failures++; end
      end
    end
    checks++; if (gaps != 0) begin $display("FAIL view_busy_continuous: %0d idle cycles want 0", gaps); failures++; end
    checks++; if (busy !== 1'b0 || digits !== 32'h77) begin $display("FAIL view_second_result: busy %b digits %h want 0/00000077", busy, digits); failures++; end
    checks++; if (segments !== SEG_77) begin $display("FAIL view_segments: got %h want %h", segments, SEG_77); failures++; end
  endtask

  task automatic test_leading_zero();
    write_ch(2'd1, 32'd7);
    repeat (34) tick();
    checks++; if (digits !== 32'h7) begin $display("FAIL lz_digits: got %h want 00000007", digits); failures++; end
    checks++; if (segments[6:0] !== 7'b1111000) begin $display("FAIL lz_seg0: got %b want 1111000", segments[6:0]); failures++; end
    checks++; if (segments !== SEG_SEVEN) begin $display("FAIL lz_segments: got %h want %h", segments, SEG_SEVEN); failures++; end
  endtask

  task automatic test_reset_abort();
    write_ch(2'd1, 32'd123);
    repeat (5) tick();
    reset = 1'b0; tick(); reset = 1'b1;
    checks++; if (busy !== 1'b0 || digits !== 32'h0 || segments !== {56{1'b1}}) begin
      $display("FAIL reset_abort: busy %b digits %h segments %h want 0/0/all 7F", busy, digits, segments); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_input();
    test_overflow();
    test_view_change();
    test_leading_zero();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
